// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one external unsigned N x N multiplier
// between two valid/ready requesters, with tag-tracked return of each product.
module mul_share_arbiter #(
  parameter int N   = 23,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [2*N-1:0] rsp0_p,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*N-1:0] rsp1_p,
  output logic           mul_valid,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_p,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         st_q [2];
  state_t         st_d [2];
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     cap;
  logic [1:0]     rsp_rdy;
  logic           ptr_q, ptr_d;
  logic           acc, acc_id;
  logic           mv_q, mid_q;
  logic [N-1:0]   ma_q, mb_q;
  logic [2*N-1:0] p_q [2];
  logic           tag_v, tag_id;

  function automatic state_t next_state(input state_t s, input logic g,
                                        input logic c, input logic r);
    state_t n;
    n = s;
    case (s)
      IDLE:    if (g) n = WAIT;
      WAIT:    if (c) n = DONE;
      DONE:    if (r) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  assign rsp_rdy  = {rsp1_ready, rsp0_ready};
  assign elig[0]  = (st_q[0] == IDLE) && req0_valid;
  assign elig[1]  = (st_q[1] == IDLE) && req1_valid;
  assign grant[0] = elig[0] && (!elig[1] || !ptr_q);
  assign grant[1] = elig[1] && (!elig[0] || ptr_q);
  assign acc      = |grant;
  assign acc_id   = grant[1];

  // Tag {valid,id} travels alongside the multiplier so the product returns to its owner.
  generate
    if (LAT == 0) begin : g_tag_comb
      assign tag_v  = mv_q;
      assign tag_id = mid_q;
    end else begin : g_tag_pipe
      logic [LAT-1:0] tv_q, tid_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tv_q  <= '0;
          tid_q <= '0;
        end else begin
          tv_q  <= LAT'({tv_q, mv_q});
          tid_q <= LAT'({tid_q, mid_q});
        end
      end
      assign tag_v  = tv_q[LAT-1];
      assign tag_id = tid_q[LAT-1];
    end
  endgenerate

  assign cap = {tag_v & tag_id, tag_v & ~tag_id};

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    ptr_d   = ptr_q;
    st_d[0] = next_state(st_q[0], grant[0], cap[0], rsp_rdy[0]);
    st_d[1] = next_state(st_q[1], grant[1], cap[1], rsp_rdy[1]);
    if (acc) ptr_d = ~acc_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0] <= IDLE;
      st_q[1] <= IDLE;
      ptr_q   <= 1'b0;
      mv_q    <= 1'b0;
      mid_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_q[0]  <= '0;
      p_q[1]  <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      ptr_q   <= ptr_d;
      mv_q    <= acc;
      if (acc) begin
        mid_q <= acc_id;
        ma_q  <= acc_id ? req1_a : req0_a;
        mb_q  <= acc_id ? req1_b : req0_b;
      end
      if (cap[0]) p_q[0] <= mul_p;
      if (cap[1]) p_q[1] <= mul_p;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = (st_q[0] == DONE);
  assign rsp1_valid = (st_q[1] == DONE);
  assign rsp0_p     = p_q[0];
  assign rsp1_p     = p_q[1];
  assign mul_valid  = mv_q;
  assign mul_a      = ma_q;
  assign mul_b      = mb_q;
  assign busy       = (st_q[0] != IDLE) || (st_q[1] != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: instance 0 (LAT=2) takes the directed steps,
// instances 0..2 (LAT 2, 0, 8) then run a continuous two-requester stream.
module tb_mul_share_arbiter;
  localparam int N = 23;
  localparam int P = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v   [3][2];
  logic         rdy [3][2];
  logic [N-1:0] a   [3][2];
  logic [N-1:0] b   [3][2];
  logic         sv  [3][2];
  logic         sr  [3][2];
  logic [P-1:0] p   [3][2];
  logic         mv  [3];
  logic [N-1:0] ma  [3];
  logic [N-1:0] mb  [3];
  logic [P-1:0] mp  [3];
  logic         bz  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 1) ? 0 : ((g == 2) ? 8 : 2);
    mul_share_arbiter #(.N(N), .LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v[g][0]), .req0_ready(rdy[g][0]), .req0_a(a[g][0]), .req0_b(b[g][0]),
      .rsp0_valid(sv[g][0]), .rsp0_ready(sr[g][0]), .rsp0_p(p[g][0]),
      .req1_valid(v[g][1]), .req1_ready(rdy[g][1]), .req1_a(a[g][1]), .req1_b(b[g][1]),
      .rsp1_valid(sv[g][1]), .rsp1_ready(sr[g][1]), .rsp1_p(p[g][1]),
      .mul_valid(mv[g]), .mul_a(ma[g]), .mul_b(mb[g]), .mul_p(mp[g]), .busy(bz[g])
    );
    if (L == 0) begin : g_mul_comb
      assign mp[g] = P'(ma[g]) * P'(mb[g]);
    end else begin : g_mul_pipe
      logic [P-1:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= P'(ma[g]) * P'(mb[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign mp[g] = pipe[L-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {mv[0], bz[0], sv[0][0], sv[0][1]}, 0);
    chk({tag, "_mul"}, {ma[0], mb[0]}, 0);
    chk({tag, "_p0"}, p[0][0], 0);
    chk({tag, "_p1"}, p[0][1], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, quiet;
    int nr [3];
    int last [3];
    bit pend [3][2];
    logic [P-1:0] ex [3][2];
    int expn [3];

    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 2; r++) begin
        v[g][r] = 1'b0; a[g][r] = '0; b[g][r] = '0; sr[g][r] = 1'b1;
      end
    do_reset();
    chk("rst_ready0", rdy[0][0], 0);

    // single op, LAT=2
    cyc(); v[0][0] = 1; a[0][0] = 3; b[0][0] = 5; #1;
    chk("t1_ready", rdy[0][0], 1);
    chk("t1_mv0", mv[0], 0);
    chk("t1_busy0", bz[0], 0);
    cyc(); v[0][0] = 0; #1;
    chk("t1_mv1", mv[0], 1);
    chk("t1_ops", {ma[0], mb[0]}, {23'd3, 23'd5});
    chk("t1_busy1", bz[0], 1);
    cyc(); #1;
    chk("t1_mv2", mv[0], 0);
    chk("t1_hold", ma[0], 3);
    chk("t1_rsp2", sv[0][0], 0);
    cyc(); #1;
    chk("t1_rsp3", sv[0][0], 0);
    chk("t1_busy3", bz[0], 1);
    cyc(); #1;
    chk("t1_rsp4", sv[0][0], 1);
    chk("t1_p", p[0][0], 15);
    chk("t1_busy4", bz[0], 1);
    cyc(); #1;
    chk("t1_rsp5", sv[0][0], 0);
    chk("t1_busy5", bz[0], 0);

    // both valid right after reset
    do_reset();
    cyc(); v[0][0] = 1; a[0][0] = 7; b[0][0] = 9; v[0][1] = 1; a[0][1] = 11; b[0][1] = 13; #1;
    chk("t2_rdy0", rdy[0][0], 1);
    chk("t2_rdy1", rdy[0][1], 0);
    cyc(); v[0][0] = 0; #1;
    chk("t2_mv1", mv[0], 1);
    chk("t2_ma1", ma[0], 7);
    chk("t2_rdy1b", rdy[0][1], 1);
    cyc(); v[0][1] = 0; #1;
    chk("t2_mv2", mv[0], 1);
    chk("t2_ops2", {ma[0], mb[0]}, {23'd11, 23'd13});
    cyc(); #1;
    chk("t2_mv3", mv[0], 0);
    cyc(); #1;
    chk("t2_rsp0", sv[0][0], 1);
    chk("t2_p0", p[0][0], 63);
    chk("t2_rsp1_early", sv[0][1], 0);
    cyc(); #1;
    chk("t2_rsp1", sv[0][1], 1);
    chk("t2_p1", p[0][1], 143);
    chk("t2_rsp0_done", sv[0][0], 0);
    cyc(); #1;
    chk("t2_idle", bz[0], 0);

    // operand extremes on requester 1
    cyc(); v[0][1] = 1; a[0][1] = 23'h7FFFFF; b[0][1] = 23'h7FFFFF; #1;
    chk("t3_rdy", rdy[0][1], 1);
    cyc(); v[0][1] = 0;
    repeat (3) cyc();
    #1;
    chk("t3_rsp", sv[0][1], 1);
    chk("t3_pmax", p[0][1], 46'h3FFFFF000001);
    cyc(); v[0][1] = 1; a[0][1] = 0; b[0][1] = 23'h7FFFFF; #1;
    chk("t3_rdy2", rdy[0][1], 1);
    cyc(); v[0][1] = 0;
    repeat (3) cyc();
    #1;
    chk("t3_rsp2", sv[0][1], 1);
    chk("t3_pzero", p[0][1], 0);

    // stalled response on requester 0 while requester 1 keeps working
    cyc(); sr[0][0] = 0; v[0][0] = 1; a[0][0] = 100; b[0][0] = 200; #1;
    chk("t4_rdy", rdy[0][0], 1);
    repeat (3) cyc();
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 0) begin v[0][1] = 1; a[0][1] = 5; b[0][1] = 6; end
      if (i == 9) v[0][1] = 0;
      #1;
      chk("t4_hold_v", sv[0][0], 1);
      chk("t4_hold_p", p[0][0], 20000);
      chk("t4_rdy0", rdy[0][0], 0);
      if (sv[0][1]) begin
        n1++;
        chk("t4_p1", p[0][1], 30);
      end
    end
    chk("t4_n1", n1, 2);
    cyc(); sr[0][0] = 1; #1;
    chk("t4_v_take", sv[0][0], 1);
    chk("t4_rdy_take", rdy[0][0], 0);
    cyc(); a[0][0] = 12; b[0][0] = 12; #1;
    chk("t4_reacc", rdy[0][0], 1);
    cyc(); v[0][0] = 0; #1;
    chk("t4_mv", mv[0], 1);
    chk("t4_ma", ma[0], 12);
    repeat (3) cyc();
    #1;
    chk("t4_rsp", sv[0][0], 1);
    chk("t4_p", p[0][0], 144);

    // reset while an op is in flight
    cyc(); v[0][0] = 1; a[0][0] = 9; b[0][0] = 9; #1;
    chk("t5_rdy", rdy[0][0], 1);
    cyc(); v[0][0] = 0; #1;
    chk("t5_mv", mv[0], 1);
    chk("t5_ma", ma[0], 9);
    cyc(); rst_n = 0; #1;
    chk_zero("t5");
    chk("t5_rdy_rst", rdy[0][0], 0);
    cyc(); rst_n = 1;
    quiet = 0;
    repeat (20) begin
      cyc(); #1;
      if (sv[0][0] || sv[0][1] || bz[0] || mv[0]) quiet++;
    end
    chk("t5_quiet", quiet, 0);
    cyc(); v[0][0] = 1; a[0][0] = 4; b[0][0] = 8; #1;
    chk("t5_rdy2", rdy[0][0], 1);
    cyc(); v[0][0] = 0;
    repeat (3) cyc();
    #1;
    chk("t5_rsp", sv[0][0], 1);
    chk("t5_p", p[0][0], 32);

    // continuous stream on all three latencies
    do_reset();
    expn[0] = 39; expn[1] = 66; expn[2] = 18;
    for (int g = 0; g < 3; g++) begin
      nr[g] = 0; last[g] = -1; pend[g][0] = 0; pend[g][1] = 0;
    end
    for (int c = 0; c < 100; c++) begin
      cyc();
      for (int g = 0; g < 3; g++)
        for (int r = 0; r < 2; r++) begin
          v[g][r] = 1;
          a[g][r] = N'($urandom);
          b[g][r] = N'($urandom);
        end
      #1;
      for (int g = 0; g < 3; g++) begin
        chk("s_one", rdy[g][0] & rdy[g][1], 0);
        for (int r = 0; r < 2; r++) begin
          if (sv[g][r]) begin
            chk("s_pend", pend[g][r], 1);
            chk("s_p", p[g][r], ex[g][r]);
            pend[g][r] = 0;
            nr[g]++;
          end
          if (rdy[g][r]) begin
            if (last[g] >= 0) chk("s_alt", r, 1 - last[g]);
            last[g] = r;
            pend[g][r] = 1;
            ex[g][r] = P'(a[g][r]) * P'(b[g][r]);
          end
        end
      end
    end
    for (int g = 0; g < 3; g++) chk("s_count", nr[g], expn[g]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
